// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch front end. Owns the PC, drives a 1-cycle imem and buffers
// {pc, instruction} in a small FIFO for IF/ID. Optional FETCH_PERF_CNT_EN adds perf counters.
`default_nettype none

module if_fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_flushed,
`endif
    output logic            if_id_valid,
    input  logic            if_id_ready,
    output logic [XLEN-1:0] if_id_pc,
    output logic [31:0]     if_id_instruction
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [0:0] {BOOT = 1'b0, RUN = 1'b1} state_t;

    state_t          state, next_state;
    logic [XLEN-1:0] pc;
    logic            inflight;
    logic [XLEN-1:0] inflight_pc;
    logic [CW-1:0]   count;
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [XLEN-1:0] fifo_pc   [FIFO_DEPTH];
    logic [31:0]     fifo_inst [FIFO_DEPTH];

    logic            pop, push, issue, redirect_run;
    logic [XLEN-1:0] target;
    logic [CW:0]     occupancy;

    assign target       = {redirect_pc[XLEN-1:2], 2'b00};
    assign if_id_valid  = (count != '0);
    assign pop          = if_id_valid & if_id_ready;
    assign redirect_run = (state == RUN) & redirect_valid;
    // A response arriving in a redirect cycle belongs to the flushed path.
    assign push         = inflight & ~redirect_run;
    assign occupancy    = (CW + 1)'(count) + (CW + 1)'(inflight) - (CW + 1)'(pop);

    assign if_id_pc          = if_id_valid ? fifo_pc[rd_ptr]   : '0;
    assign if_id_instruction = if_id_valid ? fifo_inst[rd_ptr] : NOP;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= BOOT;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        imem_req   = 1'b0;
        imem_addr  = pc;
        issue      = 1'b0;
        case (state)
            BOOT: next_state = RUN;
            RUN: begin
                if (redirect_valid) begin
                    imem_req  = 1'b1;
                    imem_addr = target;
                end else if (occupancy < DEPTH_C) begin
                    imem_req = 1'b1;
                    issue    = 1'b1;
                end
            end
            default: next_state = BOOT;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (state == BOOT) begin
            inflight <= 1'b0;
            if (redirect_valid) pc <= target;
        end else if (redirect_valid) begin
            pc          <= target + XLEN'(4);
            inflight    <= 1'b1;
            inflight_pc <= target;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc          <= pc + XLEN'(4);
                inflight_pc <= pc;
            end
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: entries are only observed while count covers them.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= inflight_pc;
            fifo_inst[wr_ptr] <= imem_rdata;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [32:0] fetched_sum, flushed_sum;
    assign fetched_sum = {1'b0, perf_fetched} + 33'(push);
    // Popped entry in the redirect cycle is accepted by decode, not discarded.
    assign flushed_sum = {1'b0, perf_flushed} + 33'(count) - 33'(pop) + 33'(inflight);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else if (state == RUN) begin
            if (push) perf_fetched <= fetched_sum[32] ? 32'hFFFF_FFFF : fetched_sum[31:0];
            if (redirect_valid)
                perf_flushed <= flushed_sum[32] ? 32'hFFFF_FFFF : flushed_sum[31:0];
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: table-driven directed check of if_fetch_unit with a 1-cycle imem model.
`default_nettype none

module tb_if_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_id_valid;
    logic        if_id_ready = 1'b1;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instruction;

    int checks   = 0;
    int failures = 0;
    int step     = 0;

    if_fetch_unit dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_id_valid(if_id_valid), .if_id_ready(if_id_ready),
        .if_id_pc(if_id_pc), .if_id_instruction(if_id_instruction)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[31:2], 2'b11} ^ 32'h1234_5600;
    endfunction

    always @(posedge clock) if (imem_req) imem_rdata <= inst_of(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%h required=%h", name, step, act, exp);
        end
    endtask

    typedef struct {
        logic        rst_n, rdv;
        logic [31:0] rpc;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] ipc;
    } vec_t;

    vec_t vt[33];

    function automatic vec_t mk(input logic r, input logic d, input logic [31:0] p, input logic y,
                                input logic q, input logic [31:0] a, input logic v, input logic [31:0] c);
        vec_t t;
        t.rst_n = r; t.rdv = d; t.rpc = p; t.rdy = y;
        t.req = q; t.addr = a; t.vld = v; t.ipc = c;
        return t;
    endfunction

    task automatic check_outputs(input logic q, input logic [31:0] a, input logic v, input logic [31:0] c);
        chk("imem_req", 32'(imem_req), 32'(q));
        chk("imem_addr", imem_addr, a);
        chk("if_id_valid", 32'(if_id_valid), 32'(v));
        chk("if_id_pc", if_id_pc, c);
        chk("if_id_instruction", if_id_instruction, v ? inst_of(c) : 32'h0000_0013);
    endtask

    task automatic cycle(input logic r, input logic d, input logic [31:0] p, input logic y);
        @(posedge clock);
        #1;
        reset = r; redirect_valid = d; redirect_pc = p; if_id_ready = y;
        @(negedge clock);
    endtask

    initial begin
        // reset, startup stream, stall, redirects, misaligned target, PC wrap, mid-stream reset, boot redirect
        vt[0]  = mk(0, 0, 0, 1,  0, 32'h0, 0, 32'h0);
        vt[1]  = mk(1, 0, 0, 1,  0, 32'h0, 0, 32'h0);
        vt[2]  = mk(1, 0, 0, 1,  1, 32'h0, 0, 32'h0);
        vt[3]  = mk(1, 0, 0, 1,  1, 32'h4, 0, 32'h0);
        vt[4]  = mk(1, 0, 0, 1,  1, 32'h8, 1, 32'h0);
        vt[5]  = mk(1, 0, 0, 1,  1, 32'hC, 1, 32'h4);
        vt[6]  = mk(1, 0, 0, 0,  0, 32'h10, 1, 32'h8);
        vt[7]  = mk(1, 0, 0, 0,  0, 32'h10, 1, 32'h8);
        vt[8]  = mk(1, 0, 0, 0,  0, 32'h10, 1, 32'h8);
        vt[9]  = mk(1, 0, 0, 1,  1, 32'h10, 1, 32'h8);
        vt[10] = mk(1, 0, 0, 1,  1, 32'h14, 1, 32'hC);
        vt[11] = mk(1, 0, 0, 1,  1, 32'h18, 1, 32'h10);
        vt[12] = mk(1, 0, 0, 0,  0, 32'h1C, 1, 32'h14);
        vt[13] = mk(1, 1, 32'hC, 0,  1, 32'hC, 1, 32'h14);
        vt[14] = mk(1, 0, 0, 1,  1, 32'h10, 0, 32'h0);
        vt[15] = mk(1, 0, 0, 1,  1, 32'h14, 1, 32'hC);
        vt[16] = mk(1, 1, 32'hE, 1,  1, 32'hC, 1, 32'h10);
        vt[17] = mk(1, 0, 0, 1,  1, 32'h10, 0, 32'h0);
        vt[18] = mk(1, 0, 0, 1,  1, 32'h14, 1, 32'hC);
        vt[19] = mk(1, 1, 32'hFFFF_FFFC, 1,  1, 32'hFFFF_FFFC, 1, 32'h10);
        vt[20] = mk(1, 0, 0, 1,  1, 32'h0, 0, 32'h0);
        vt[21] = mk(1, 0, 0, 1,  1, 32'h4, 1, 32'hFFFF_FFFC);
        vt[22] = mk(1, 0, 0, 0,  0, 32'h8, 1, 32'h0);
        vt[23] = mk(0, 0, 0, 0,  0, 32'h0, 0, 32'h0);
        vt[24] = mk(1, 0, 0, 1,  0, 32'h0, 0, 32'h0);
        vt[25] = mk(1, 0, 0, 1,  1, 32'h0, 0, 32'h0);
        vt[26] = mk(1, 0, 0, 1,  1, 32'h4, 0, 32'h0);
        vt[27] = mk(1, 0, 0, 1,  1, 32'h8, 1, 32'h0);
        vt[28] = mk(0, 0, 0, 1,  0, 32'h0, 0, 32'h0);
        vt[29] = mk(1, 1, 32'h40, 1,  0, 32'h0, 0, 32'h0);
        vt[30] = mk(1, 0, 0, 1,  1, 32'h40, 0, 32'h0);
        vt[31] = mk(1, 0, 0, 1,  1, 32'h44, 0, 32'h0);
        vt[32] = mk(1, 0, 0, 1,  1, 32'h48, 1, 32'h40);

        for (int i = 0; i < 33; i++) begin
            step = i;
            cycle(vt[i].rst_n, vt[i].rdv, vt[i].rpc, vt[i].rdy);
            check_outputs(vt[i].req, vt[i].addr, vt[i].vld, vt[i].ipc);
        end

        // Stall from a fresh reset: two entries buffered, head held, then 0,4,8 back to back.
        step = 100;
        cycle(0, 0, 0, 0);
        check_outputs(0, 32'h0, 0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            step = 101 + i;
            cycle(1, 0, 0, 0);
        end
        check_outputs(0, 32'h8, 1, 32'h0);
        step = 106; cycle(1, 0, 0, 1); check_outputs(1, 32'h8, 1, 32'h0);
        step = 107; cycle(1, 0, 0, 1); check_outputs(1, 32'hC, 1, 32'h4);
        step = 108; cycle(1, 0, 0, 1); check_outputs(1, 32'h10, 1, 32'h8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
